// File: rtl/array_col_sequencer.sv
// -----------------------------------------------------------------------------
// array_col_sequencer
//
// Purpose:
//    Captures one packed vector of COLS elements and streams it out one column
//    per beat over a valid/ready interface. A new vector may be accepted on the
//    same cycle as the final beat of the current one, so consecutive frames
//    stream with no idle cycle between them.
//
// Parameters:
//    BIT_WIDTH  width of one column element in bits
//    COLS       number of columns per packed vector (2..256)
//
// Ports:
//    clk        sole clock, rising edge
//    rst        synchronous, active-high reset
//    in         packed input vector; column i at [i*BIT_WIDTH +: BIT_WIDTH]
//    in_valid   the value on in is offered
//    in_ready   the block accepts in this cycle
//    out        current column element (0 while idle)
//    out_col    index of the column on out (0 while idle)
//    out_last   out_col is the final column of the frame
//    out_valid  out, out_col and out_last are valid
//    out_ready  the downstream consumer accepts the beat
//
// Build option:
//    ARRAY_COL_SEQ_REVERSE_EN  when defined, columns stream from COLS-1 down to
//                              0 and out_last marks column 0. When undefined,
//                              columns stream from 0 up to COLS-1.
// -----------------------------------------------------------------------------
module array_col_sequencer #(
   parameter int BIT_WIDTH = 4,
   parameter int COLS      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [COLS*BIT_WIDTH-1:0] in,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [BIT_WIDTH-1:0]      out,
   output logic [$clog2(COLS)-1:0]   out_col,
   output logic                      out_last,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int               COL_W   = $clog2(COLS);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

`ifdef ARRAY_COL_SEQ_REVERSE_EN
   localparam logic [COL_W-1:0] COL_FIRST = COL_MAX;
   localparam logic [COL_W-1:0] COL_FINAL = '0;
`else
   localparam logic [COL_W-1:0] COL_FIRST = '0;
   localparam logic [COL_W-1:0] COL_FINAL = COL_MAX;
`endif

   typedef enum logic {
      S_IDLE,     // no frame held
      S_STREAM    // frame held, beats pending
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [COL_W-1:0]          r_col;
   logic [COL_W-1:0]          w_col_next;
   logic [COL_W-1:0]          w_col_step;
   logic [COLS*BIT_WIDTH-1:0] r_data;
   logic [BIT_WIDTH-1:0]      w_elem;
   logic                      w_last;
   logic                      w_load;
   logic                      w_out_hs;

   // Neighbouring column in streaming order. The counter only steps on a
   // non-last beat, so it can never walk past COL_MAX even when COLS is not a
   // power of two.
`ifdef ARRAY_COL_SEQ_REVERSE_EN
   assign w_col_step = r_col - COL_W'(1);
`else
   assign w_col_step = r_col + COL_W'(1);
`endif

   // Column select written as a compare-per-column mux so no index can ever
   // reach past the top of r_data.
   always_comb begin
      w_elem = '0;
      for (int i = 0; i < COLS; i++) begin
         if (r_col == COL_W'(i)) begin
            w_elem = r_data[i*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and handshake logic
   // -------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default before the case statement;
   // a path that left one unassigned would infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_col_next   = r_col;
      out_valid    = 1'b0;
      in_ready     = 1'b0;
      w_last       = 1'b0;

      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
         end
         S_STREAM: begin
            out_valid = 1'b1;
            w_last    = (r_col == COL_FINAL);
            // Accept the next frame only when the final beat leaves this very
            // cycle; this is what removes the bubble between frames. It never
            // looks at in_valid, so no combinational path runs in_valid->in_ready.
            in_ready  = w_last & out_ready;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase

      w_load   = in_valid & in_ready;
      w_out_hs = out_valid & out_ready;

      case (r_state)
         S_IDLE: begin
            if (w_load) begin
               w_state_next = S_STREAM;
               w_col_next   = COL_FIRST;
            end
         end
         S_STREAM: begin
            if (w_out_hs) begin
               if (!w_last) begin
                  w_col_next = w_col_step;
               end else if (w_load) begin
                  w_col_next = COL_FIRST;
               end else begin
                  // Park the counter at 0 so out_col reads 0 while idle in
                  // both streaming orders.
                  w_state_next = S_IDLE;
                  w_col_next   = '0;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_col_next   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before this edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_col   <= '0;
      end else begin
         r_state <= w_state_next;
         r_col   <= w_col_next;
      end
   end

   // NOTE: the frame buffer is deliberately not reset. It is only observed
   // while in S_STREAM, which can only be reached through a load, and out is
   // forced to 0 while idle, so clearing it would add reset fan-out for nothing.
   // A load during reset is harmless because the state stays in S_IDLE.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_data <= in;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign out      = (r_state == S_STREAM) ? w_elem : '0;
   assign out_col  = r_col;
   assign out_last = w_last;

   // -------------------------------------------------------------------------
   // Invariants
   // -------------------------------------------------------------------------
   a_col_in_range : assert property (@(posedge clk) disable iff (rst)
      r_col <= COL_MAX);

   a_idle_col_zero : assert property (@(posedge clk) disable iff (rst)
      (r_state == S_IDLE) |-> (r_col == '0));

endmodule

// File: tb/tb_array_col_sequencer.sv
// -----------------------------------------------------------------------------
// tb_array_col_sequencer
//
// Directed bench for array_col_sequencer. Two instances share clk/rst:
//    dut8  default parameters (COLS=8, BIT_WIDTH=4)
//    dut5  COLS=5, BIT_WIDTH=4 (non power-of-two column count)
// Expected column order follows ARRAY_COL_SEQ_REVERSE_EN so the same bench
// covers either build. Inputs change 1 time unit after a rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_array_col_sequencer;

`ifdef ARRAY_COL_SEQ_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif

   localparam logic [31:0] FRAME_A = 32'h76543210;
   localparam logic [31:0] FRAME_B = 32'hFEDCBA98;
   localparam logic [31:0] FRAME_C = 32'h13579BDF;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] in8;
   logic        in_valid8;
   logic        in_ready8;
   logic [3:0]  out8;
   logic [2:0]  out_col8;
   logic        out_last8;
   logic        out_valid8;
   logic        out_ready8;

   logic [19:0] in5;
   logic        in_valid5;
   logic        in_ready5;
   logic [3:0]  out5;
   logic [2:0]  out_col5;
   logic        out_last5;
   logic        out_valid5;
   logic        out_ready5;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   array_col_sequencer #(.BIT_WIDTH(4), .COLS(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in        (in8),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .out       (out8),
      .out_col   (out_col8),
      .out_last  (out_last8),
      .out_valid (out_valid8),
      .out_ready (out_ready8)
   );

   array_col_sequencer #(.BIT_WIDTH(4), .COLS(5)) dut5 (
      .clk       (clk),
      .rst       (rst),
      .in        (in5),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
      .out       (out5),
      .out_col   (out_col5),
      .out_last  (out_last5),
      .out_valid (out_valid5),
      .out_ready (out_ready5)
   );

   // Column presented on beat k of a frame.
   function automatic int col_at(input int cols, input int k);
      return REV ? (cols - 1 - k) : k;
   endfunction

   // Element of a 32-bit frame at a given column.
   function automatic logic [3:0] nib(input logic [31:0] d, input int c);
      return d[c*4 +: 4];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packed view: {out_valid, out_last, out_col, out, in_ready}
   task automatic test_reset();
      logic [9:0] got;
      logic [9:0] exp;
      rst        = 1'b1;
      in8        = FRAME_B;
      in_valid8  = 1'b1;   // handshake offered during reset must be ignored
      out_ready8 = 1'b1;
      in5        = 20'hABCDE;
      in_valid5  = 1'b1;
      out_ready5 = 1'b1;
      repeat (3) tick();
      rst       = 1'b0;
      in_valid8 = 1'b0;
      in_valid5 = 1'b0;
      @(negedge clk);
      exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b1};
      got = {out_valid8, out_last8, out_col8, out8, in_ready8};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL reset_dut8: got %b expected %b", got, exp);
      end
      got = {out_valid5, out_last5, out_col5, out5, in_ready5};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL reset_dut5: got %b expected %b", got, exp);
      end
      // Stays idle with nothing offered.
      tick();
      @(negedge clk);
      checks++;
      if (out_valid8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold: out_valid got %b expected 0", out_valid8);
      end
   endtask

   task automatic check_idle8(input string name);
      logic [9:0] got;
      logic [9:0] exp;
      exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b1};
      got = {out_valid8, out_last8, out_col8, out8, in_ready8};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s_idle: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic test_single_frame();
      logic [9:0] got;
      logic [9:0] exp;
      int         c;
      tick();
      in8        = FRAME_A;
      in_valid8  = 1'b1;
      out_ready8 = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready8, out_valid8} !== 2'b10) begin
         failures++;
         $display("FAIL single_accept: in_ready/out_valid got %b expected 10",
                  {in_ready8, out_valid8});
      end
      tick();
      in_valid8 = 1'b0;
      in8       = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         c   = col_at(8, k);
         exp = {1'b1, (k == 7), 3'(c), nib(FRAME_A, c), (k == 7)};
         got = {out_valid8, out_last8, out_col8, out8, in_ready8};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL single_beat%0d: got %b expected %b", k, got, exp);
         end
         tick();
      end
      @(negedge clk);
      check_idle8("single");
   endtask

   task automatic test_back_to_back();
      logic [9:0] got;
      logic [9:0] exp;
      int         c;
      tick();
      in8        = FRAME_A;
      in_valid8  = 1'b1;
      out_ready8 = 1'b1;
      tick();
      // FRAME_B is offered from here on; only the final beat of frame A may take it.
      in8 = FRAME_B;
      for (int k = 0; k < 16; k++) begin
         in_valid8 = (k != 15);
         @(negedge clk);
         c   = col_at(8, k % 8);
         exp = {1'b1, (k % 8 == 7), 3'(c),
                (k < 8) ? nib(FRAME_A, c) : nib(FRAME_B, c), (k % 8 == 7)};
         got = {out_valid8, out_last8, out_col8, out8, in_ready8};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL b2b_beat%0d: got %b expected %b", k, got, exp);
         end
         tick();
      end
      in_valid8 = 1'b0;
      @(negedge clk);
      check_idle8("b2b");
   endtask

   task automatic test_stall();
      int         rdy [12] = '{1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
      int         idx;
      int         c;
      logic [9:0] got;
      logic [9:0] exp;
      tick();
      in8        = FRAME_A;
      in_valid8  = 1'b1;
      out_ready8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      idx       = 0;
      for (int t = 0; t < 12 && idx < 8; t++) begin
         out_ready8 = rdy[t][0];
         @(negedge clk);
         c   = col_at(8, idx);
         exp = {1'b1, (idx == 7), 3'(c), nib(FRAME_A, c),
                (idx == 7) && (rdy[t] != 0)};
         got = {out_valid8, out_last8, out_col8, out8, in_ready8};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL stall_t%0d: got %b expected %b", t, got, exp);
         end
         if (rdy[t] != 0) idx++;
         tick();
      end
      out_ready8 = 1'b1;
      @(negedge clk);
      check_idle8("stall");
   endtask

   task automatic test_ignore_busy_input();
      logic [9:0] got;
      logic [9:0] exp;
      int         c;
      tick();
      in8        = FRAME_A;
      in_valid8  = 1'b1;
      out_ready8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         // Different data offered on non-last beats only.
         in_valid8 = (k >= 1 && k <= 5);
         in8       = FRAME_C;
         @(negedge clk);
         c   = col_at(8, k);
         exp = {1'b1, (k == 7), 3'(c), nib(FRAME_A, c), (k == 7)};
         got = {out_valid8, out_last8, out_col8, out8, in_ready8};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL ignore_beat%0d: got %b expected %b", k, got, exp);
         end
         tick();
      end
      in_valid8 = 1'b0;
      @(negedge clk);
      check_idle8("ignore");
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] got;
      logic [9:0] exp;
      int         c;
      int         kk;
      kk = REV ? 4 : 3;   // beat on which column 3 is presented
      tick();
      in8        = FRAME_A;
      in_valid8  = 1'b1;
      out_ready8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      for (int k = 0; k <= kk; k++) begin
         if (k == kk) begin
            rst       = 1'b1;
            in_valid8 = 1'b1;
            in8       = FRAME_B;
         end
         @(negedge clk);
         c   = col_at(8, k);
         exp = {1'b1, 1'b0, 3'(c), nib(FRAME_A, c), 1'b0};
         got = {out_valid8, out_last8, out_col8, out8, in_ready8};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL rstmid_beat%0d: got %b expected %b", k, got, exp);
         end
         tick();
      end
      rst       = 1'b0;
      in_valid8 = 1'b0;
      @(negedge clk);
      check_idle8("rstmid");
      // No leftover beat of the discarded frame may appear.
      for (int t = 0; t < 4; t++) begin
         tick();
         @(negedge clk);
         checks++;
         if (out_valid8 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet%0d: out_valid got %b expected 0", t, out_valid8);
         end
      end
      tick();
      in8       = FRAME_C;
      in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         c   = col_at(8, k);
         exp = {1'b1, (k == 7), 3'(c), nib(FRAME_C, c), (k == 7)};
         got = {out_valid8, out_last8, out_col8, out8, in_ready8};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL rstmid_new%0d: got %b expected %b", k, got, exp);
         end
         tick();
      end
      @(negedge clk);
      check_idle8("rstmid_new");
   endtask

   task automatic test_cols5();
      logic [9:0] got;
      logic [9:0] exp;
      int         c;
      tick();
      in5        = 20'h43210;
      in_valid5  = 1'b1;
      out_ready5 = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready5, out_valid5} !== 2'b10) begin
         failures++;
         $display("FAIL cols5_accept: in_ready/out_valid got %b expected 10",
                  {in_ready5, out_valid5});
      end
      tick();
      in_valid5 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         c   = col_at(5, k);
         exp = {1'b1, (k == 4), 3'(c), 4'(c), (k == 4)};
         got = {out_valid5, out_last5, out_col5, out5, in_ready5};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL cols5_beat%0d: got %b expected %b", k, got, exp);
         end
         tick();
      end
      @(negedge clk);
      exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b1};
      got = {out_valid5, out_last5, out_col5, out5, in_ready5};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL cols5_idle: got %b expected %b", got, exp);
      end
   endtask

   initial begin
      rst        = 1'b1;
      in8        = '0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      in5        = '0;
      in_valid5  = 1'b0;
      out_ready5 = 1'b1;

      test_reset();
      test_single_frame();
      test_back_to_back();
      test_stall();
      test_ignore_busy_input();
      test_reset_mid_frame();
      test_cols5();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/array_col_sequencer.md
ARRAY_COL_SEQUENCER -- requirements
Module: array_col_sequencer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4, width of one column element in bits.
REQ-002 SHALL have parameter COLS, default 8, number of columns per packed vector; legal range 2..256.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in  input  COLS*BIT_WIDTH  packed vector; column i at bits [i*BIT_WIDTH+BIT_WIDTH-1 : i*BIT_WIDTH].
REQ-006 SHALL have port in_valid  input  1  the value on in is offered.
REQ-007 SHALL have port in_ready  output  1  the block accepts in this cycle.
REQ-008 SHALL have port out  output  BIT_WIDTH  current column element.
REQ-009 SHALL have port out_col  output  $clog2(COLS)  index of the column on out.
REQ-010 SHALL have port out_last  output  1  high when out_col equals the final column of the frame.
REQ-011 SHALL have port out_valid  output  1  out, out_col and out_last are valid.
REQ-012 SHALL have port out_ready  input  1  the downstream consumer accepts the beat.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no frame held) and STREAM (frame held, beats pending).
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 An input handshake (in_valid & in_ready) SHALL capture in into an internal COLS*BIT_WIDTH register, set the column counter to the first column, and enter STREAM.
REQ-016 Latency: out_valid SHALL rise in the cycle after the input handshake, with the first column on out.
REQ-017 In STREAM, out_valid SHALL be 1 and out SHALL equal the captured column selected by out_col.
REQ-018 Once presented, out, out_col and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 An output handshake (out_valid & out_ready) on a non-last beat SHALL advance the counter by one column on the next cycle.
REQ-020 An output handshake on the last beat SHALL return the FSM to IDLE, unless the back-to-back rule in REQ-021 applies.
REQ-021 Back-to-back: in STREAM, in_ready SHALL equal out_last & out_ready; an input handshake in that cycle SHALL load the new frame and remain in STREAM, with no bubble between frames.
REQ-022 in_ready SHALL be 0 in STREAM on every non-last beat; input data offered in those cycles SHALL be ignored.
REQ-023 A frame SHALL emit exactly COLS beats, and out_last SHALL be 1 on exactly one of them.
REQ-024 The column counter SHALL never exceed COLS-1, including when COLS is not a power of two.
REQ-025 in_ready SHALL depend combinationally only on state, out_last and out_ready, and never on in_valid.

Reset
REQ-026 While rst=1 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear to 0.
REQ-027 After reset, the outputs SHALL be: out_valid=0, in_ready=1, out_last=0, out_col=0, out=0.
REQ-028 Reset asserted mid-frame SHALL discard the remaining beats, and no beat of that frame SHALL appear after rst deasserts.
REQ-029 rst SHALL take priority over any simultaneous input or output handshake.

Configuration
REQ-030 With macro ARRAY_COL_SEQ_REVERSE_EN defined, columns SHALL be emitted in the order COLS-1 down to 0: the counter loads COLS-1, decrements, and out_last marks column 0.
REQ-031 Without ARRAY_COL_SEQ_REVERSE_EN, columns SHALL be emitted in the order 0 up to COLS-1, and out_last SHALL mark column COLS-1.
REQ-032 Reset values SHALL be the same in both builds (out_col=0 while idle).

Verification
REQ-033 Default params, in=32'h76543210, in_valid pulse, out_ready=1 -> out = 0,1,...,7 on 8 consecutive cycles starting 1 cycle after the handshake; out_last only on out_col=7; then IDLE.
REQ-034 Two frames 32'h76543210 and 32'hFEDCBA98 with in_valid held and out_ready=1 -> 16 contiguous beats 0..F, with in_ready=1 only in the handshake cycles.
REQ-035 out_ready toggled 1,0,0,1 during a frame -> out and out_col held while stalled, no beat dropped or duplicated.
REQ-036 rst=1 during beat out_col=3 -> the next cycle has out_valid=0 and in_ready=1; a new frame then starts at column 0.
REQ-037 COLS=5 with ARRAY_COL_SEQ_REVERSE_EN defined, in=20'h43210 -> out = 4,3,2,1,0, with out_last on column 0.
REQ-038 in_valid=1 on a non-last beat with different data -> that data is ignored and the current frame completes unchanged.
